ps2_fifo_port: RTL and testbench

PS2_FIFO_PORT -- requirements
Module: ps2_fifo_port

---
 rtl/ps2_pkg.sv | 41 ++++
 rtl/ps2_rx_fifo.sv | 50 +++++
 rtl/ps2_fifo_port.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ps2_fifo_port.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host port: FSM states, register map,
// STATUS bit positions and the bus request bundle.
package ps2_pkg;

   typedef enum logic [1:0] {RX_IDLE, RX_DEBOUNCE, RX_SAMPLE} rx_state_e;

   typedef enum logic [2:0] {
      TX_IDLE, TX_INHIBIT, TX_REQ, TX_SHIFT, TX_ACK, TX_DONE
   } tx_state_e;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_COUNT  = 2'd3;

   localparam int ST_RXNE   = 7;
   localparam int ST_TXBUSY = 6;
   localparam int ST_TXDONE = 5;
   localparam int ST_NACK   = 4;
   localparam int ST_TOUT   = 3;
   localparam int ST_OVF    = 2;
   localparam int ST_FERR   = 1;
   localparam int ST_PERR   = 0;

   typedef struct packed {
      logic       vld;
      logic       we;
      logic       lane0;
      logic [1:0] adr;
      logic [7:0] dat;
   } bus_req_t;

   function automatic logic maj7(input logic [6:0] v);
      return ($countones(v) > 3);
   endfunction

   function automatic logic odd_par(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Receive byte FIFO; a pop on empty is a no-op and reads back 0x00.
module ps2_rx_fifo #(
   parameter int unsigned pDepth = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [7:0]                 wdat_i,
   input  logic                       pop_i,
   output logic [7:0]                 rdat_o,
   output logic [$clog2(pDepth):0]    count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int AW = $clog2(pDepth);

   logic [7:0]    mem [pDepth];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign full_o  = (cnt == (AW+1)'(pDepth));
   assign empty_o = (cnt == '0);
   // a pop in the same cycle frees the slot, so a push into a full FIFO is kept
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o;
   assign rdat_o  = empty_o ? 8'h00 : mem[rd_ptr];
   assign count_o = cnt;

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wdat_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/ps2_fifo_port.sv
// PS/2 host port: filtered receiver into a byte FIFO, host-to-device transmitter
// with watchdog, and a four-register bus slave.
module ps2_fifo_port
   import ps2_pkg::*;
#(
   parameter int unsigned pClkFreq     = 50000000,
   parameter int unsigned pFifoDepth   = 16,
   parameter int unsigned pTxTimeoutUs = 30000,
   parameter bit          pEnTx        = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cs_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [3:0]  sel_i,
   input  logic [3:0]  adr_i,
   input  logic [31:0] dat_i,
   output logic        ack_o,
   output logic [31:0] dat_o,
   output logic        irq_o,
   input  logic        kclk_i,
   input  logic        kdat_i,
   output logic        kclk_en_o,
   output logic        kdat_en_o
);
   localparam int unsigned CYC_US   = (pClkFreq < 1000000) ? 1 : pClkFreq / 1000000;
   localparam int unsigned DEB_CYC  = 5 * CYC_US;
   localparam int unsigned INH_CYC  = 100 * CYC_US;
   localparam int unsigned RXTO_CYC = 2000 * CYC_US;
   localparam int unsigned TXTO_CYC = pTxTimeoutUs * CYC_US;
   localparam int DBW = $clog2(DEB_CYC + 1);
   localparam int INW = $clog2(INH_CYC + 1);
   localparam int RXW = $clog2(RXTO_CYC + 1);
   localparam int WDW = $clog2(TXTO_CYC + 1);
   localparam int CW  = $clog2(pFifoDepth) + 1;

   bus_req_t   req;
   logic       ack_q, acc_new, rd_acc, wr_acc, pop, wr_data, tx_start;
   logic [7:0] dat_q, rd_mux, status, count8;
   logic [8:0] cnt9;
   logic [2:0] ctrl;
   logic [5:0] w1c;
   logic       st_done, st_nack, st_tout, st_ovf, st_ferr, st_perr;
   logic       unused_bits;

   logic [1:0] kclk_sync, kdat_sync;
   logic [6:0] kclk_sh, kdat_sh;
   logic       kclk_f, kdat_f, kclk_fd, kclk_fall;

   rx_state_e  rx_st, rx_nxt;
   logic [DBW-1:0] rx_tmr;
   logic [RXW-1:0] rx_gap;
   logic [3:0]  rx_bits;
   logic [10:0] rx_sh, rx_frame;
   logic        rx_last, rx_push, rx_gap_hit;

   tx_state_e  tx_st, tx_nxt;
   logic [INW-1:0] tx_tmr;
   logic [WDW-1:0] wd_tmr;
   logic [3:0] tx_bit;
   logic [7:0] tx_byte;
   logic [9:0] tx_frame;
   logic       tx_pend, tx_shot, tx_drv, tx_busy, wd_run, wd_hit;

   logic [7:0]    fifo_rdat;
   logic [CW-1:0] fifo_cnt;
   logic          fifo_full, fifo_empty;

   assign unused_bits = ^{dat_i[31:8], adr_i[1:0], sel_i[3:1]};

   always_comb begin
      req.vld   = cs_i & cyc_i & stb_i;
      req.we    = we_i;
      req.lane0 = sel_i[0];
      req.adr   = adr_i[3:2];
      req.dat   = dat_i[7:0];
   end

   // side effects fire once, on the first cycle of an access
   assign acc_new  = req.vld & ~ack_q;
   assign rd_acc   = acc_new & ~req.we;
   assign wr_acc   = acc_new & req.we & req.lane0;
   assign pop      = rd_acc & (req.adr == REG_DATA);
   assign wr_data  = wr_acc & (req.adr == REG_DATA);
   assign tx_start = wr_data & ~tx_busy & pEnTx;
   assign w1c      = (wr_acc && req.adr == REG_STATUS) ? req.dat[5:0] : 6'h00;

   assign cnt9   = 9'(fifo_cnt);
   assign count8 = cnt9[8] ? 8'hFF : cnt9[7:0];

   always_comb begin
      status            = 8'h00;
      status[ST_RXNE]   = ~fifo_empty;
      status[ST_TXBUSY] = tx_busy;
      status[ST_TXDONE] = st_done;
      status[ST_NACK]   = st_nack;
      status[ST_TOUT]   = st_tout;
      status[ST_OVF]    = st_ovf;
      status[ST_FERR]   = st_ferr;
      status[ST_PERR]   = st_perr;
   end

   always_comb begin
      unique case (req.adr)
         REG_DATA:   rd_mux = fifo_rdat;
         REG_STATUS: rd_mux = status;
         REG_CTRL:   rd_mux = {5'b0, ctrl};
         default:    rd_mux = count8;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_q <= 1'b0;
         dat_q <= 8'h00;
         ctrl  <= 3'b000;
      end else begin
         ack_q <= req.vld;
         if (!req.vld)    dat_q <= 8'h00;
         else if (acc_new) dat_q <= req.we ? 8'h00 : rd_mux;
         if (wr_acc && req.adr == REG_CTRL) ctrl <= req.dat[2:0];
      end
   end

   assign ack_o = ack_q;
   assign dat_o = {4{dat_q}};
   assign irq_o = (ctrl[0] & ~fifo_empty) | (ctrl[1] & (st_done | st_tout));

   // line filtering; idle-high reset values keep reset release edge-free
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         kclk_sync <= '1;
         kdat_sync <= '1;
         kclk_sh   <= '1;
         kdat_sh   <= '1;
         kclk_f    <= 1'b1;
         kdat_f    <= 1'b1;
         kclk_fd   <= 1'b1;
      end else begin
         kclk_sync <= {kclk_sync[0], kclk_i};
         kdat_sync <= {kdat_sync[0], kdat_i};
         kclk_sh   <= {kclk_sh[5:0], kclk_sync[1]};
         kdat_sh   <= {kdat_sh[5:0], kdat_sync[1]};
         kclk_f    <= maj7(kclk_sh);
         kdat_f    <= maj7(kdat_sh);
         kclk_fd   <= kclk_f;
      end
   end

   assign kclk_fall = kclk_fd & ~kclk_f;

   // receiver
   assign rx_frame   = {kdat_f, rx_sh[10:1]};
   assign rx_last    = (rx_st == RX_SAMPLE) && (rx_bits == 4'd10);
   assign rx_push    = rx_last & ~rx_frame[0] & rx_frame[10] & (^rx_frame[9:1]);
   assign rx_gap_hit = (rx_bits != 4'd0) && (rx_gap == RXW'(RXTO_CYC - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rx_st <= RX_IDLE;
      else         rx_st <= rx_nxt;
   end

   always_comb begin
      rx_nxt = rx_st;
      unique case (rx_st)
         RX_IDLE:     if (kclk_fall) rx_nxt = RX_DEBOUNCE;
         RX_DEBOUNCE: if (kclk_f) rx_nxt = RX_IDLE;
                      else if (rx_tmr == DBW'(DEB_CYC - 1)) rx_nxt = RX_SAMPLE;
         default:     rx_nxt = RX_IDLE;
      endcase
      if (tx_busy) rx_nxt = RX_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_tmr  <= '0;
         rx_gap  <= '0;
         rx_bits <= 4'd0;
         rx_sh   <= '0;
      end else begin
         rx_tmr <= (rx_st == RX_DEBOUNCE) ? rx_tmr + 1'b1 : '0;
         rx_gap <= (rx_bits == 4'd0 || kclk_fall) ? '0 : rx_gap + 1'b1;
         if (rx_st == RX_SAMPLE) rx_sh <= rx_frame;
         if (tx_busy || rx_gap_hit)  rx_bits <= 4'd0;
         else if (rx_st == RX_SAMPLE) rx_bits <= rx_last ? 4'd0 : rx_bits + 4'd1;
      end
   end

   ps2_rx_fifo #(.pDepth(pFifoDepth)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (rx_push),
      .wdat_i  (rx_frame[8:1]),
      .pop_i   (pop),
      .rdat_o  (fifo_rdat),
      .count_o (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // transmitter
   assign tx_busy  = (tx_st != TX_IDLE);
   assign tx_frame = {1'b1, odd_par(tx_byte), tx_byte};
   assign tx_shot  = (tx_st == TX_SHIFT) && tx_pend && (tx_tmr == INW'(DEB_CYC - 1));
   assign wd_run   = (tx_st == TX_REQ) || (tx_st == TX_SHIFT) ||
                     (tx_st == TX_ACK) || (tx_st == TX_DONE);
   assign wd_hit   = wd_run && (wd_tmr == WDW'(TXTO_CYC - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) tx_st <= TX_IDLE;
      else         tx_st <= tx_nxt;
   end

   always_comb begin
      tx_nxt = tx_st;
      unique case (tx_st)
         TX_IDLE:    if (tx_start) tx_nxt = TX_INHIBIT;
         TX_INHIBIT: if (tx_tmr == INW'(INH_CYC - 1)) tx_nxt = TX_REQ;
         TX_REQ:     if (kclk_fall) tx_nxt = TX_SHIFT;
         TX_SHIFT:   if (tx_shot && tx_bit == 4'd9) tx_nxt = TX_ACK;
         TX_ACK:     if (kclk_fall) tx_nxt = TX_DONE;
         TX_DONE:    if (kclk_f) tx_nxt = TX_IDLE;
         default:    tx_nxt = TX_IDLE;
      endcase
      if (wd_hit) tx_nxt = TX_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_tmr  <= '0;
         wd_tmr  <= '0;
         tx_bit  <= 4'd0;
         tx_pend <= 1'b0;
         tx_drv  <= 1'b0;
         tx_byte <= 8'h00;
      end else begin
         tx_tmr <= (tx_st == TX_INHIBIT || (tx_st == TX_SHIFT && tx_pend)) ? tx_tmr + 1'b1 : '0;
         wd_tmr <= wd_run ? wd_tmr + 1'b1 : '0;
         if (tx_start) tx_byte <= req.dat;
         // each device falling edge arms a 5 us delay before the next bit is driven
         if (tx_st == TX_REQ && kclk_fall) begin
            tx_pend <= 1'b1;
            tx_bit  <= 4'd0;
         end else if (tx_shot) begin
            tx_pend <= 1'b0;
            tx_bit  <= tx_bit + 4'd1;
         end else if (tx_st == TX_SHIFT && kclk_fall) begin
            tx_pend <= 1'b1;
         end else if (tx_st != TX_SHIFT) begin
            tx_pend <= 1'b0;
         end
         if (tx_nxt == TX_IDLE)                          tx_drv <= 1'b0;
         else if (tx_st == TX_INHIBIT && tx_nxt == TX_REQ) tx_drv <= 1'b1;
         else if (tx_shot)                               tx_drv <= ~tx_frame[tx_bit];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         {st_done, st_nack, st_tout, st_ovf, st_ferr, st_perr} <= '0;
      end else begin
         st_done <= (tx_st == TX_DONE && kclk_f && !wd_hit) | (st_done & ~w1c[5]);
         st_nack <= (tx_st == TX_ACK && kclk_fall && kdat_f && !wd_hit) | (st_nack & ~w1c[4]);
         st_tout <= wd_hit | (st_tout & ~w1c[3]);
         st_ovf  <= (rx_push & fifo_full & ~pop) | (st_ovf & ~w1c[2]);
         st_ferr <= (rx_last & (rx_frame[0] | ~rx_frame[10])) | rx_gap_hit | (st_ferr & ~w1c[1]);
         st_perr <= (rx_last & ~(^rx_frame[9:1])) | (st_perr & ~w1c[0]);
      end
   end

   assign kclk_en_o = fifo_full | ctrl[2] | (tx_st == TX_INHIBIT);
   assign kdat_en_o = tx_drv;

endmodule

// File: tb/tb_ps2_fifo_port.sv
// Directed bench for ps2_fifo_port at 1 MHz (1 cycle = 1 us) with a PS/2 device model.
module tb_ps2_fifo_port;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cs = 0, cyc = 0, stb = 0, we = 0;
   logic [3:0]  sel = 0, adr = 0;
   logic [31:0] wdat = 0;
   logic        ack_o, irq_o, kclk_en_o, kdat_en_o;
   logic [31:0] dat_o;
   logic        kclk = 1'b1, kdat = 1'b1;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   ps2_fifo_port #(.pClkFreq(1000000), .pFifoDepth(16), .pTxTimeoutUs(30000), .pEnTx(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .cs_i(cs), .cyc_i(cyc), .stb_i(stb), .we_i(we),
      .sel_i(sel), .adr_i(adr), .dat_i(wdat), .ack_o(ack_o), .dat_o(dat_o), .irq_o(irq_o),
      .kclk_i(kclk), .kdat_i(kdat), .kclk_en_o(kclk_en_o), .kdat_en_o(kdat_en_o));

   typedef struct {
      logic [7:0] b;
      logic       bad_par;
      logic [7:0] cnt;
      logic [7:0] st;
      logic [7:0] dat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic bus_acc(input logic w, input logic [1:0] a, input logic [7:0] v,
                          output logic [31:0] rd);
      int n;
      @(negedge clk);
      cs = 1; cyc = 1; stb = 1; we = w; sel = 4'hF; adr = {a, 2'b00}; wdat = {24'h0, v};
      n = 0;
      do begin @(negedge clk); n++; end while (!ack_o && n < 8);
      if (!ack_o) chk("bus_ack", 32'(ack_o), 32'd1);
      rd = dat_o;
      cs = 0; cyc = 0; stb = 0; we = 0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] v);
      logic [31:0] d;
      bus_acc(1'b1, a, v, d);
   endtask

   task automatic rdchk(input string nm, input logic [1:0] a, input logic [7:0] e);
      logic [31:0] d;
      bus_acc(1'b0, a, 8'h00, d);
      chk(nm, d, {4{e}});
   endtask

   task automatic dev_bit(input logic b);
      kdat = b;
      repeat (10) @(negedge clk);
      kclk = 1'b0;
      repeat (20) @(negedge clk);
      kclk = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) dev_bit(f[i]);
      kdat = 1'b1;
      repeat (50) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      vec_t        vecs[5];
      logic [9:0]  got;
      logic [10:0] f;
      int          n;

      vecs[0] = '{8'h1C, 1'b0, 8'd1, 8'h80, 8'h1C};
      vecs[1] = '{8'h55, 1'b1, 8'd0, 8'h01, 8'h00};
      vecs[2] = '{8'h00, 1'b0, 8'd1, 8'h80, 8'h00};
      vecs[3] = '{8'hFF, 1'b0, 8'd1, 8'h80, 8'hFF};
      vecs[4] = '{8'h80, 1'b1, 8'd0, 8'h01, 8'h00};

      repeat (4) @(negedge clk);
      chk("rst_ack", 32'(ack_o), 0);
      chk("rst_dat", dat_o, 0);
      chk("rst_irq", 32'(irq_o), 0);
      chk("rst_kclk_en", 32'(kclk_en_o), 0);
      chk("rst_kdat_en", 32'(kdat_en_o), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      rdchk("rst_status", 2'd1, 8'h00);
      rdchk("rst_ctrl", 2'd2, 8'h00);
      rdchk("rst_count", 2'd3, 8'h00);

      wr(2'd2, 8'h05);
      rdchk("ctrl_rb", 2'd2, 8'h05);
      chk("inhibit_kclk", 32'(kclk_en_o), 1);
      wr(2'd2, 8'h01);
      chk("inhibit_off", 32'(kclk_en_o), 0);

      for (int i = 0; i < 5; i++) begin
         wr(2'd1, 8'h3F);
         send_frame(vecs[i].b, vecs[i].bad_par);
         rdchk($sformatf("v%0d_count", i), 2'd3, vecs[i].cnt);
         rdchk($sformatf("v%0d_status", i), 2'd1, vecs[i].st);
         chk($sformatf("v%0d_irq", i), 32'(irq_o), 32'(vecs[i].cnt != 0));
         rdchk($sformatf("v%0d_data", i), 2'd0, vecs[i].dat);
         rdchk($sformatf("v%0d_count_after", i), 2'd3, 8'h00);
      end

      // overflow: 17 frames into 16 entries
      do_reset();
      for (int i = 0; i < 17; i++) send_frame(8'(8'h30 + i), 1'b0);
      rdchk("ovf_count", 2'd3, 8'h10);
      rdchk("ovf_status", 2'd1, 8'h84);
      chk("ovf_kclk_en", 32'(kclk_en_o), 1);
      rdchk("ovf_head", 2'd0, 8'h30);
      chk("ovf_kclk_rel", 32'(kclk_en_o), 0);
      rdchk("ovf_count2", 2'd3, 8'h0F);

      // host write 0xED, device acknowledges
      do_reset();
      wr(2'd2, 8'h02);
      wr(2'd0, 8'hED);
      wr(2'd0, 8'h12);
      n = 0;
      while (kclk_en_o && n < 300) begin @(negedge clk); n++; end
      chk("tx_inh_len", 32'(n >= 90 && n <= 101), 1);
      chk("tx_req_dat", 32'(kdat_en_o), 1);
      for (int i = 0; i < 10; i++) begin
         kclk = 1'b0;
         repeat (20) @(negedge clk);
         got[i] = ~kdat_en_o;
         kclk = 1'b1;
         repeat (20) @(negedge clk);
      end
      kdat = 1'b0;
      repeat (10) @(negedge clk);
      kclk = 1'b0;
      repeat (20) @(negedge clk);
      kclk = 1'b1;
      repeat (10) @(negedge clk);
      kdat = 1'b1;
      repeat (20) @(negedge clk);
      chk("tx_byte", 32'(got[7:0]), 32'h00ED);
      chk("tx_parity", 32'(got[8]), 1);
      chk("tx_stop", 32'(got[9]), 1);
      rdchk("tx_status", 2'd1, 8'h20);
      chk("tx_irq", 32'(irq_o), 1);
      wr(2'd1, 8'h20);
      chk("tx_irq_clr", 32'(irq_o), 0);
      chk("tx_dat_rel", 32'(kdat_en_o), 0);

      // host write 0xFF, device never clocks
      do_reset();
      wr(2'd2, 8'h02);
      wr(2'd0, 8'hFF);
      repeat (50) @(negedge clk);
      chk("to_inh_clk", 32'(kclk_en_o), 1);
      chk("to_inh_dat", 32'(kdat_en_o), 0);
      repeat (100) @(negedge clk);
      chk("to_req_clk", 32'(kclk_en_o), 0);
      chk("to_req_dat", 32'(kdat_en_o), 1);
      repeat (28800) @(negedge clk);
      rdchk("to_busy", 2'd1, 8'h40);
      repeat (1500) @(negedge clk);
      rdchk("to_status", 2'd1, 8'h08);
      chk("to_clk_rel", 32'(kclk_en_o), 0);
      chk("to_dat_rel", 32'(kdat_en_o), 0);
      chk("to_irq", 32'(irq_o), 1);

      // reset while bit 5 of a frame is on the wire
      do_reset();
      f = {1'b1, ~^8'h3C, 8'h3C, 1'b0};
      for (int i = 0; i < 5; i++) dev_bit(f[i]);
      kdat = f[5];
      repeat (10) @(negedge clk);
      kclk = 1'b0;
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_rst_clk", 32'(kclk_en_o), 0);
      chk("mid_rst_dat", 32'(kdat_en_o), 0);
      kclk = 1'b1;
      kdat = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      rdchk("mid_count", 2'd3, 8'h00);
      rdchk("mid_status", 2'd1, 8'h00);
      send_frame(8'hAA, 1'b0);
      rdchk("aa_count", 2'd3, 8'h01);
      rdchk("aa_data", 2'd0, 8'hAA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
